multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
// - Control FSM for the multicycle MIPS datapath: a single ALU and a single unified memory are reused across cycles.
// - Sequences fetch, decode, execute, memory and writeback for R-type, lw, sw, addi, beq and j.
// - Drives every datapath mux select and write enable, and stalls on a memory ready handshake.
// - Sits beside the ALU decoder: it supplies ALUOp, and the ALU decoder turns ALUOp plus Funct into ALU control.
// PARAMETERS
// - CNT_W  32  width of the retired-instruction counter
// PORTS
// - Interface decided: one clock; reset asynchronous, active-high.
// - clk          in   1      rising-edge clock
// - reset        in   1      asynchronous, active-high reset
// - Op           in   6      opcode; IR[31:26] from the instruction register
// - mem_ready    in   1      memory has completed the current access this cycle
// - mem_req      out  1      memory access request
// - IorD         out  1      memory address select: 0 = PC, 1 = ALUOut
// - IRWrite      out  1      instruction register load enable
// - PCWrite      out  1      unconditional PC write
// - Branch       out  1      conditional PC write; datapath gates it with Zero
// - PCSrc        out  2      PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
// - ALUSrcA      out  1      ALU A operand: 0 = PC, 1 = register A
// - ALUSrcB      out  2      ALU B operand: 00 = register B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
// - ALUOp        out  2      00 = add, 01 = sub, 10 = use Funct
// - RegDst       out  1      register write address: 0 = rt, 1 = rd
// - MemToReg     out  1      register write data: 0 = ALUOut, 1 = memory data
// - RegWrite     out  1      register file write enable
// - MemWrite     out  1      memory write enable
// - illegal_op   out  1      sticky flag: an unsupported opcode was decoded
// - retired      out  CNT_W  count of completed instructions
// - state        out  4      current state, for debug
// BEHAVIOUR
// - Reset (asynchronous):
//   - State goes to FETCH; retired = 0; illegal_op = 0.
//   - While reset is high, all enables are forced to 0: IRWrite, PCWrite, Branch, RegWrite, MemWrite, mem_req.
// - Outputs are Moore (decoded from state) except IRWrite/PCWrite in FETCH, which are qualified by mem_ready.
// - Every unlisted enable is 0 and every unlisted select is 0.
// - States and outputs (-> next state):
//   - FETCH: mem_req, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
//     IRWrite = PCWrite = mem_ready. -> DECODE when mem_ready, else hold.
//   - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op:
//     - 100011 (lw) or 101011 (sw) -> MEMADR
//     - 000000 (R-type) -> EXECUTE
//     - 001000 (addi) -> ADDIEX
//     - 000100 (beq) -> BRANCH
//     - 000010 (j) -> JUMP
//     - any other Op -> FETCH, and illegal_op is set.
//   - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> MEMREAD for lw, MEMWRITE for sw.
//   - MEMREAD: mem_req, IorD=1. -> MEMWB on mem_ready, else hold.
//   - MEMWB: RegDst=0, MemToReg=1, RegWrite=1. -> FETCH.
//   - MEMWRITE: mem_req, IorD=1, MemWrite=1, asserted for the whole wait. -> FETCH on mem_ready.
//   - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> ALUWB.
//   - ALUWB: RegDst=1, MemToReg=0, RegWrite=1. -> FETCH.
//   - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDIWB.
//   - ADDIWB: RegDst=0, MemToReg=0, RegWrite=1. -> FETCH.
//   - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. -> FETCH.
//   - JUMP: PCSrc=10, PCWrite=1. -> FETCH.
// - Latency with zero memory wait: R-type/addi = 4 cycles, lw = 5, sw = 4, beq = 3, j = 3.
//   Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
// - retired increments by 1 on each transition into FETCH from:
//   MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH or JUMP. An illegal opcode does not count. Wraps modulo 2^CNT_W.
// - Op is sampled only in DECODE and MEMADR. Changes to Op in any other state have no effect.
// - mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
// - Reset mid-instruction, including mid-MEMWRITE: state goes straight to FETCH and MemWrite drops immediately.
//   No partial writeback is issued afterwards.
// - Unreachable state encodings recover to FETCH on the next clock.
// STRUCTURE
// - Shared package mips_pkg holds:
//   - state enum: 12 states, 4 bits
//   - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J
//   - encodings for ALUOp, ALUSrcB and PCSrc
// - One sub-module, mc_control_rom: combinational state -> control word.
//   The top level holds the state register, next-state logic, mem_ready qualification, retired counter and illegal_op.
// TESTING
// - Reset: assert reset mid-EXECUTE.
//   -> state=FETCH, all enables 0, retired=0 asynchronously; after release, FETCH asserts mem_req.
// - R-type (Op=000000), mem_ready tied 1:
//   -> state sequence FETCH, DECODE, EXECUTE, ALUWB; RegWrite=1 with RegDst=1 in cycle 4; retired 0->1.
// - lw (Op=100011), mem_ready low for 2 cycles in MEMREAD:
//   -> MEMREAD held 3 cycles, MEMWB has MemToReg=1, total 7 cycles.
// - sw (Op=101011), mem_ready low for 1 cycle:
//   -> MemWrite=1 for 2 cycles with IorD=1, RegWrite never 1, then FETCH.
// - beq then j:
//   -> BRANCH drives ALUOp=01, PCSrc=01, Branch=1; JUMP drives PCWrite=1, PCSrc=10; retired +2.
// - Illegal Op=111111:
//   -> DECODE goes to FETCH, illegal_op=1 and stays set, retired unchanged; the next legal instruction runs normally.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and encodings for the multicycle MIPS controller
// Purpose: FSM state enum, opcode constants, select encodings and the control word.
// Ports: none (package).
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_ADDIEX   = 4'd8,
    S_ADDIWB   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
  } ctrl_t;

endpackage

// File: rtl/mc_control_rom.sv
// rtl/mc_control_rom.sv - combinational state to control word decode
// Purpose: Moore control word for each FSM state; unlisted fields are 0.
// Ports: state (in, 4) current state; ctrl (out, ctrl_t) control word.
//        FETCH returns ir_write/pc_write unqualified; the top gates them with mem_ready.
module mc_control_rom
  import mips_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control FSM for the multicycle MIPS datapath
// Purpose: sequences fetch/decode/execute/memory/writeback, drives datapath selects
//          and enables, stalls on mem_ready, counts retired instructions.
// Ports: clk, reset (async, active-high); Op opcode; mem_ready memory handshake;
//        mem_req, IorD, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
//        RegDst, MemToReg, RegWrite, MemWrite datapath controls;
//        illegal_op sticky flag; retired instruction count; state for debug.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic [1:0]       PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  state_t cur;
  state_t nxt;
  ctrl_t  ctrl;
  logic   retire;
  logic   bad_op;

  mc_control_rom u_rom (
    .state (cur),
    .ctrl  (ctrl)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    nxt    = S_FETCH;
    retire = 1'b0;
    bad_op = 1'b0;
    case (cur)
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXECUTE;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          default: begin
            nxt    = S_FETCH;
            bad_op = 1'b1;
          end
        endcase
      end
      S_MEMADR:  nxt = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: nxt = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: begin
        nxt    = mem_ready ? S_FETCH : S_MEMWRITE;
        retire = mem_ready;
      end
      S_EXECUTE: nxt = S_ALUWB;
      S_ADDIEX:  nxt = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired    <= '0;
      illegal_op <= 1'b0;
    end else begin
      if (retire) retired <= retired + CNT_W'(1);
      if (bad_op) illegal_op <= 1'b1;
    end
  end

  // Enables are gated by reset so a write in flight (e.g. MemWrite) drops
  // the instant reset rises, not at the next edge.
  always_comb begin
    state    = cur;
    mem_req  = ctrl.mem_req & ~reset;
    IorD     = ctrl.iord;
    IRWrite  = ctrl.ir_write & mem_ready & ~reset;
    PCWrite  = ctrl.pc_write & (mem_ready | (cur != S_FETCH)) & ~reset;
    Branch   = ctrl.branch & ~reset;
    PCSrc    = ctrl.pc_src;
    ALUSrcA  = ctrl.alu_src_a;
    ALUSrcB  = ctrl.alu_src_b;
    ALUOp    = ctrl.alu_op;
    RegDst   = ctrl.reg_dst;
    MemToReg = ctrl.mem_to_reg;
    RegWrite = ctrl.reg_write & ~reset;
    MemWrite = ctrl.mem_write & ~reset;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  Op = 6'd0;
  logic        mem_ready = 1'b1;
  logic        mem_req, IorD, IRWrite, PCWrite, Branch, ALUSrcA;
  logic        RegDst, MemToReg, RegWrite, MemWrite, illegal_op;
  logic [1:0]  PCSrc, ALUSrcB, ALUOp;
  logic [31:0] retired;
  logic [3:0]  state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] w;
    int          ret;
    logic        ill;
  } exp_t;
  exp_t q[$];

  // Output word: mem_req IorD IRWrite PCWrite Branch PCSrc[2] ALUSrcA ALUSrcB[2] ALUOp[2] RegDst MemToReg RegWrite MemWrite
  logic [15:0] w_act;
  assign w_act = {mem_req, IorD, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA,
                  ALUSrcB, ALUOp, RegDst, MemToReg, RegWrite, MemWrite};

  localparam logic [15:0] W_FETCH   = 16'hB040;
  localparam logic [15:0] W_FETCH_S = 16'h8040;
  localparam logic [15:0] W_DECODE  = 16'h00C0;
  localparam logic [15:0] W_MEMADR  = 16'h0180;
  localparam logic [15:0] W_MEMREAD = 16'hC000;
  localparam logic [15:0] W_MEMWB   = 16'h0006;
  localparam logic [15:0] W_MEMWR   = 16'hC001;
  localparam logic [15:0] W_EXEC    = 16'h0120;
  localparam logic [15:0] W_ALUWB   = 16'h000A;
  localparam logic [15:0] W_ADDIEX  = 16'h0180;
  localparam logic [15:0] W_ADDIWB  = 16'h0002;
  localparam logic [15:0] W_BRANCH  = 16'h0B10;
  localparam logic [15:0] W_JUMP    = 16'h1400;
  localparam logic [15:0] EN_MASK   = 16'hB803;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .illegal_op(illegal_op), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: the controller presents a fresh output every cycle; compare at negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("state", 32'(state), 32'(e.st));
        chk("ctrl_word", 32'(w_act), 32'(e.w));
        chk("retired", retired, 32'(e.ret));
        chk("illegal_op", 32'(illegal_op), 32'(e.ill));
      end
    end
  end

  task automatic cyc(input logic [5:0] o, input logic r, input logic [3:0] s,
                     input logic [15:0] w, input int ret, input logic ill);
    Op = o;
    mem_ready = r;
    q.push_back('{s, w, ret, ill});
    @(posedge clk);
    #1;
  endtask

  task automatic reset_now(input string tag);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk({tag, "_state"}, 32'(state), 32'(S_FETCH));
    chk({tag, "_enables"}, 32'(w_act & EN_MASK), 32'd0);
    chk({tag, "_memwrite"}, 32'(MemWrite), 32'd0);
    chk({tag, "_retired"}, retired, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_state", 32'(state), 32'(S_FETCH));
    chk("rst_enables", 32'(w_act & EN_MASK), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // R-type, zero wait
    cyc(OP_RTYPE, 1, S_FETCH,   W_FETCH, 0, 0);
    cyc(OP_RTYPE, 1, S_DECODE,  W_DECODE, 0, 0);
    cyc(OP_RTYPE, 1, S_EXECUTE, W_EXEC, 0, 0);
    cyc(OP_RTYPE, 1, S_ALUWB,   W_ALUWB, 0, 0);
    // second R-type, reset in EXECUTE
    cyc(OP_RTYPE, 1, S_FETCH,   W_FETCH, 1, 0);
    cyc(OP_RTYPE, 1, S_DECODE,  W_DECODE, 1, 0);
    Op = OP_RTYPE;
    q.push_back('{S_EXECUTE, W_EXEC, 1, 1'b0});
    reset_now("rst_exec");

    // lw with two wait cycles in MEMREAD; mem_ready low in MEMADR is ignored
    cyc(OP_LW, 1, S_FETCH,   W_FETCH, 0, 0);
    cyc(OP_LW, 1, S_DECODE,  W_DECODE, 0, 0);
    cyc(OP_LW, 0, S_MEMADR,  W_MEMADR, 0, 0);
    cyc(OP_LW, 0, S_MEMREAD, W_MEMREAD, 0, 0);
    cyc(OP_LW, 0, S_MEMREAD, W_MEMREAD, 0, 0);
    cyc(OP_LW, 1, S_MEMREAD, W_MEMREAD, 0, 0);
    cyc(OP_LW, 1, S_MEMWB,   W_MEMWB, 0, 0);

    // sw with one fetch stall and one write wait
    cyc(OP_SW, 0, S_FETCH,    W_FETCH_S, 1, 0);
    cyc(OP_SW, 1, S_FETCH,    W_FETCH, 1, 0);
    cyc(OP_SW, 1, S_DECODE,   W_DECODE, 1, 0);
    cyc(OP_SW, 1, S_MEMADR,   W_MEMADR, 1, 0);
    cyc(OP_SW, 0, S_MEMWRITE, W_MEMWR, 1, 0);
    cyc(OP_SW, 1, S_MEMWRITE, W_MEMWR, 1, 0);

    // beq (Op change in BRANCH has no effect), then j
    cyc(OP_BEQ, 1, S_FETCH,  W_FETCH, 2, 0);
    cyc(OP_BEQ, 1, S_DECODE, W_DECODE, 2, 0);
    cyc(6'h3F,  1, S_BRANCH, W_BRANCH, 2, 0);
    cyc(OP_J,   1, S_FETCH,  W_FETCH, 3, 0);
    cyc(OP_J,   1, S_DECODE, W_DECODE, 3, 0);
    cyc(OP_J,   1, S_JUMP,   W_JUMP, 3, 0);

    // illegal opcode, then addi runs normally
    cyc(6'h3F,   1, S_FETCH,  W_FETCH, 4, 0);
    cyc(6'h3F,   1, S_DECODE, W_DECODE, 4, 0);
    cyc(OP_ADDI, 1, S_FETCH,  W_FETCH, 4, 1);
    cyc(OP_ADDI, 1, S_DECODE, W_DECODE, 4, 1);
    cyc(OP_ADDI, 1, S_ADDIEX, W_ADDIEX, 4, 1);
    cyc(OP_ADDI, 1, S_ADDIWB, W_ADDIWB, 4, 1);
    cyc(OP_SW,   1, S_FETCH,  W_FETCH, 5, 1);

    // sw interrupted by reset while MemWrite is held
    cyc(OP_SW, 1, S_DECODE,   W_DECODE, 5, 1);
    cyc(OP_SW, 1, S_MEMADR,   W_MEMADR, 5, 1);
    Op = OP_SW;
    mem_ready = 1'b0;
    q.push_back('{S_MEMWRITE, W_MEMWR, 5, 1'b1});
    reset_now("rst_memwr");
    mem_ready = 1'b1;
    cyc(OP_SW, 1, S_FETCH, W_FETCH, 0, 0);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) chk("scoreboard_drain", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
